// File: rtl/square32_seq_if.sv
// Request/result bundle for the iterative squarer: start/y in, busy/rdy/x out.
interface square32_seq_if #(
  parameter int IN_W = 16
);
  logic              start;
  logic [IN_W-1:0]   y;
  logic              busy;
  logic              rdy;
  logic [2*IN_W-1:0] x;

  modport master (output start, y, input busy, rdy, x);
  modport slave  (input start, y, output busy, rdy, x);
endinterface

// File: rtl/square32_seq.sv
// Iterative shift-add squarer: x = y*y with one add/shift step per clock and
// a fixed IN_W+1 cycle latency from the accepting edge to rdy.
module square32_seq #(
  parameter int IN_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  square32_seq_if.slave bus
);
  localparam int X_W   = 2 * IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [X_W-1:0]   mcand_q, mcand_d;
  logic [X_W-1:0]   acc_q,   acc_d;
  logic [X_W-1:0]   x_q,     x_d;
  logic [IN_W-1:0]  mplr_q,  mplr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    x_d     = x_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          mcand_d = {{IN_W{1'b0}}, bus.y};
          mplr_d  = bus.y;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // start is deliberately not looked at here: a run cannot be restarted.
        if (cnt_q != CNT_LAST) begin
          if (mplr_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          x_d     = acc_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.rdy  = (state_q == S_DONE);
  assign bus.x    = x_q;
endmodule

// File: tb/tb_square32_seq.sv
// Directed and randomized checks of square32_seq against an arithmetic model.
module tb_square32_seq;
  localparam int IN_W = 16;
  localparam int LAT  = IN_W + 1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   lat;

  square32_seq_if #(.IN_W(IN_W)) bus ();

  square32_seq #(.IN_W(IN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sq_model(input logic [15:0] v);
    longint a;
    a = longint'(v);
    return 32'(a * a);
  endfunction

  function automatic longint isqrt(input longint v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after an edge; leaves time just after the accepting edge.
  task automatic launch(input logic [15:0] yv);
    bus.start = 1'b1;
    bus.y     = yv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.y     = 16'($urandom);
  endtask

  task automatic wait_rdy(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.rdy) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] ry;
    logic        seen;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.y     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_rdy",  64'(bus.rdy),  64'd0);
    check("reset_x",    64'(bus.x),    64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    launch(16'h0001);
    check("y1_busy_run", 64'(bus.busy), 64'd1);
    check("y1_rdy_run",  64'(bus.rdy),  64'd0);
    wait_rdy(lat);
    check("y1_latency", 64'(lat), 64'(LAT));
    check("y1_x", 64'(bus.x), 64'h0000_0001);
    check("y1_busy_done", 64'(bus.busy), 64'd0);

    launch(16'h0080);
    wait_rdy(lat);
    check("y80_latency", 64'(lat), 64'(LAT));
    check("y80_x", 64'(bus.x), 64'h0000_4000);
    check("y80_roundtrip", 64'(isqrt(longint'(bus.x))), 64'h80);

    launch(16'hFFFF);
    wait_rdy(lat);
    check("yffff_x", 64'(bus.x), 64'hFFFE_0001);

    launch(16'h0000);
    wait_rdy(lat);
    check("y0_latency", 64'(lat), 64'(LAT));
    check("y0_x", 64'(bus.x), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("y0_rdy_held", 64'(bus.rdy), 64'd1);
    check("y0_x_held", 64'(bus.x), 64'd0);

    launch(16'h1234);
    check("restart_rdy_fall", 64'(bus.rdy), 64'd0);
    check("restart_busy", 64'(bus.busy), 64'd1);
    wait_rdy(lat);
    check("y1234_latency", 64'(lat), 64'(LAT));
    check("y1234_x", 64'(bus.x), 64'h014B_5A90);

    launch(16'h00FF);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    bus.y     = 16'h0002;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("ignore_busy", 64'(bus.busy), 64'd1);
    wait_rdy(lat);
    check("ignore_latency", 64'(lat + 5), 64'(LAT));
    check("ignore_x", 64'(bus.x), 64'h0000_FE01);

    for (int i = 0; i < 20; i++) begin
      ry = 16'($urandom);
      launch(ry);
      check("rand_rdy_fall", 64'(bus.rdy), 64'd0);
      wait_rdy(lat);
      check("rand_latency", 64'(lat), 64'(LAT));
      check("rand_x", 64'(bus.x), 64'(sq_model(ry)));
      check("rand_busy_done", 64'(bus.busy), 64'd0);
    end

    launch(16'hABCD);
    repeat (7) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", 64'(bus.busy), 64'd0);
    check("async_rdy",  64'(bus.rdy),  64'd0);
    check("async_x",    64'(bus.x),    64'd0);
    #3;
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.rdy || bus.busy) seen = 1'b1;
    end
    check("no_rdy_after_reset", 64'(seen), 64'd0);

    ry = 16'($urandom);
    launch(ry);
    wait_rdy(lat);
    check("recover_latency", 64'(lat), 64'(LAT));
    check("recover_x", 64'(bus.x), 64'(sq_model(ry)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
